// File: rtl/uart_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Package   : uart_pkg                                                     |
// | Purpose   : Shared types and constants for the UART receive packetizer:  |
// |             character width, default start-of-frame marker, err_flags    |
// |             bit positions and the packetizer FSM state encoding.         |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
package uart_pkg;

  localparam int NUM_DATA_BITS = 8;

  localparam logic [NUM_DATA_BITS-1:0] DEFAULT_SOF_BYTE = 8'hA5;

  // Bit positions inside err_flags = {overrun, timeout, bad_len, bad_sum}
  localparam int ERR_OVERRUN = 3;
  localparam int ERR_TIMEOUT = 2;
  localparam int ERR_BAD_LEN = 1;
  localparam int ERR_BAD_SUM = 0;

  // ST_GET_CHK is only ever entered when the checksum option is built in.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_LEN  = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_GET_CHK  = 3'd3,
    ST_HOLD     = 3'd4
  } pkt_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_pkt_buf.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module    : uart_pkt_buf                                                 |
// | Purpose   : Payload store for the packetizer. DEPTH x WIDTH register     |
// |             array, one synchronous write port, one combinational read.  |
// |             Contents are deliberately not reset.                         |
// | Ports     : clk    - write clock                                         |
// |             we     - write enable                                        |
// |             waddr  - write index                                         |
// |             wdata  - write data                                          |
// |             raddr  - read index                                          |
// |             rdata  - data at raddr (zero when raddr >= DEPTH)            |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module uart_pkt_buf #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Guard keeps non-power-of-two depths from indexing past the array.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) begin
      rdata = mem[raddr];
    end
  end

endmodule : uart_pkt_buf
`default_nettype wire

// File: rtl/uart_rx_packetizer.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module    : uart_rx_packetizer                                           |
// | Purpose   : Assembles framed packets (SOF, LEN, payload[, CHK]) from a   |
// |             byte stream delivered by an upstream UART receiver, holds    |
// |             the completed packet for a consumer and records sticky       |
// |             error flags.                                                 |
// | Options   : UART_PKT_CHECKSUM_EN - when defined, a trailing XOR checksum |
// |             byte is expected and checked (bad_sum flag). When undefined  |
// |             the packet ends after the payload and err_flags[0] is 0.     |
// | Ports     : baud      - clock, rising edge                               |
// |             reset     - asynchronous active-low reset                    |
// |             rx_data   - received byte                                    |
// |             rx_done   - one-cycle strobe qualifying rx_data              |
// |             rx_error  - upstream framing/parity error with rx_done       |
// |             pkt_valid - a complete packet is held                        |
// |             pkt_len   - payload length of the held packet                |
// |             rd_addr   - payload read index                               |
// |             rd_data   - payload byte at rd_addr (combinational)          |
// |             pkt_ack   - consumer releases the held packet                |
// |             err_flags - sticky {overrun, timeout, bad_len, bad_sum}      |
// |             err_clr   - clears err_flags on the next edge                |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module uart_rx_packetizer
  import uart_pkg::*;
#(
  parameter int                       MAX_LEN        = 16,
  parameter logic [NUM_DATA_BITS-1:0] SOF_BYTE       = DEFAULT_SOF_BYTE,
  parameter int                       TIMEOUT_CYCLES = 1024,
  localparam int                      ADDR_W         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                     baud,
  input  logic                     reset,
  input  logic [NUM_DATA_BITS-1:0] rx_data,
  input  logic                     rx_done,
  input  logic                     rx_error,
  output logic                     pkt_valid,
  output logic [7:0]               pkt_len,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [NUM_DATA_BITS-1:0] rd_data,
  input  logic                     pkt_ack,
  output logic [3:0]               err_flags,
  input  logic                     err_clr
);

  localparam int                 CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]         MAX_LEN_B = 8'(MAX_LEN);

  pkt_state_e       state, state_next;
  logic [7:0]       len_q, len_next;
  logic [7:0]       idx_q, idx_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [3:0]       err_q, err_next;
  logic [3:0]       err_event;
  logic             buf_we;
`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0]       csum_q, csum_next;
`endif

  //--------------------------------------------------------------------------
  // State and datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge baud or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      len_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
`ifdef UART_PKT_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state  <= state_next;
      len_q  <= len_next;
      idx_q  <= idx_next;
      cnt_q  <= cnt_next;
      err_q  <= err_next;
`ifdef UART_PKT_CHECKSUM_EN
      csum_q <= csum_next;
`endif
    end
  end

  //--------------------------------------------------------------------------
  // Next-state and event logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    len_next   = len_q;
    idx_next   = idx_q;
    cnt_next   = '0;      // timer only runs while a packet is in flight
    err_event  = '0;
    buf_we     = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
    csum_next  = csum_q;
`endif

    case (state)
      ST_IDLE: begin
        if (rx_done && !rx_error && (rx_data == SOF_BYTE)) begin
          state_next = ST_GET_LEN;
        end
      end

      ST_GET_LEN: begin
        cnt_next = cnt_q + 1'b1;
        if (rx_done) begin
          cnt_next = '0;
          if (rx_error) begin
            state_next = ST_IDLE;
          end else if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            err_event[ERR_BAD_LEN] = 1'b1;
            state_next             = ST_IDLE;
          end else begin
            len_next   = rx_data;
            idx_next   = '0;
            state_next = ST_GET_DATA;
`ifdef UART_PKT_CHECKSUM_EN
            csum_next  = rx_data;   // checksum covers LEN as well
`endif
          end
        end else if (cnt_q == TO_LAST) begin
          err_event[ERR_TIMEOUT] = 1'b1;
          state_next             = ST_IDLE;
        end
      end

      ST_GET_DATA: begin
        cnt_next = cnt_q + 1'b1;
        if (rx_done) begin
          cnt_next = '0;
          if (rx_error) begin
            state_next = ST_IDLE;
          end else begin
            buf_we   = 1'b1;
            idx_next = idx_q + 8'd1;
`ifdef UART_PKT_CHECKSUM_EN
            csum_next = csum_q ^ rx_data;
            if (idx_q == (len_q - 8'd1)) state_next = ST_GET_CHK;
`else
            if (idx_q == (len_q - 8'd1)) state_next = ST_HOLD;
`endif
          end
        end else if (cnt_q == TO_LAST) begin
          err_event[ERR_TIMEOUT] = 1'b1;
          state_next             = ST_IDLE;
        end
      end

`ifdef UART_PKT_CHECKSUM_EN
      ST_GET_CHK: begin
        cnt_next = cnt_q + 1'b1;
        if (rx_done) begin
          cnt_next = '0;
          if (rx_error) begin
            state_next = ST_IDLE;
          end else if (rx_data == csum_q) begin
            state_next = ST_HOLD;
          end else begin
            err_event[ERR_BAD_SUM] = 1'b1;
            state_next             = ST_IDLE;
          end
        end else if (cnt_q == TO_LAST) begin
          err_event[ERR_TIMEOUT] = 1'b1;
          state_next             = ST_IDLE;
        end
      end
`endif

      ST_HOLD: begin
        // Buffer write enable stays low here, so the held payload is frozen.
        if (rx_done) begin
          err_event[ERR_OVERRUN] = 1'b1;
        end
        if (pkt_ack) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A new event is OR-ed in after the clear so it survives a coincident clear.
  always_comb begin
    err_next = (err_clr ? 4'b0000 : err_q) | err_event;
`ifndef UART_PKT_CHECKSUM_EN
    err_next[ERR_BAD_SUM] = 1'b0;
`endif
  end

  //--------------------------------------------------------------------------
  // Payload buffer
  //--------------------------------------------------------------------------
  uart_pkt_buf #(
    .DEPTH  (MAX_LEN),
    .WIDTH  (NUM_DATA_BITS),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (baud),
    .we    (buf_we),
    .waddr (idx_q[ADDR_W-1:0]),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign pkt_valid = (state == ST_HOLD);
  assign pkt_len   = len_q;
  assign err_flags = err_q;

endmodule : uart_rx_packetizer
`default_nettype wire
